// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : Shared definitions for the serial CRC generator: default
//               parameter values, FSM state encoding and the Galois LFSR
//               single-step function (right shift, LSB-first data).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package crc_pkg;

    localparam int          c_DEF_WIDTH   = 8;
    localparam logic [31:0] c_DEF_TAPS    = 32'h0000_0044;
    localparam logic [31:0] c_DEF_SEED    = 32'h0000_00D8;
    localparam logic [31:0] c_DEF_XOR_OUT = 32'h0000_00FF;

    typedef logic [1:0] crc_state_t;
    localparam crc_state_t c_ST_IDLE  = 2'd0;
    localparam crc_state_t c_ST_SHIFT = 2'd1;
    localparam crc_state_t c_ST_OUT   = 2'd2;

    // One Galois step on a zero-extended register of 'width' live bits.
    // Bits at and above 'width' in the result are always zero.
    function automatic logic [31:0] crc_step(
        input logic [31:0] lfsr,
        input logic [31:0] taps,
        input int          width,
        input logic        din
    );
        logic        fb;
        logic [31:0] shifted;
        logic [31:0] nxt;
        fb      = din ^ lfsr[0];
        shifted = lfsr >> 1;
        nxt     = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == width - 1) begin
                nxt[i] = fb;
            end else if (i < width - 1) begin
                nxt[i] = shifted[i] ^ (taps[i] & fb);
            end
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : crc_lfsr_core
// Description : WIDTH-bit Galois LFSR register. Seed load has priority over
//               a shift step; otherwise the register holds.
// Ports       : clk         - clock, rising edge
//               rst_n       - asynchronous active-low reset (loads SEED)
//               i_load_seed - load SEED on the next edge
//               i_shift     - absorb i_data with one LFSR step
//               i_data      - serial data bit
//               o_lfsr      - current LFSR contents
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module crc_lfsr_core
    import crc_pkg::*;
#(
    parameter int               WIDTH = c_DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = c_DEF_TAPS[WIDTH-1:0],
    parameter logic [WIDTH-1:0] SEED  = c_DEF_SEED[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_seed,
    input  logic             i_shift,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_lfsr
);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_next;

    assign w_next = WIDTH'(crc_step(32'(r_lfsr), 32'(TAPS), WIDTH, i_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_load_seed) begin
            r_lfsr <= SEED;
        end else if (i_shift) begin
            r_lfsr <= w_next;
        end
    end

    assign o_lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/crc_serial_gen.sv
`default_nettype none
// ============================================================================
// Module      : crc_serial_gen
// Description : Serial CRC generator. Absorbs a frame LSB-first while ACTIVE
//               is high, then streams the WIDTH-bit CRC out LSB-first with a
//               valid strobe lasting exactly WIDTH cycles.
//               Optional build macro CRC_FINAL_XOR_EN: the CRC is XORed with
//               XOR_OUT before it is streamed out.
// Ports       : CLK    - clock, rising edge
//               RST    - asynchronous active-low reset
//               Data   - serial data bit
//               ACTIVE - frame enable (data phase while high)
//               CRC    - serial CRC bit, meaningful while valid=1
//               valid  - CRC stream strobe
//               BUSY   - frame in progress (SHIFT or OUT)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module crc_serial_gen
    import crc_pkg::*;
#(
    parameter int          WIDTH   = c_DEF_WIDTH,
    parameter logic [31:0] TAPS    = c_DEF_TAPS,
    parameter logic [31:0] SEED    = c_DEF_SEED,
    parameter logic [31:0] XOR_OUT = c_DEF_XOR_OUT
) (
    input  logic CLK,
    input  logic RST,
    input  logic Data,
    input  logic ACTIVE,
    output logic CRC,
    output logic valid,
    output logic BUSY
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH);

    crc_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_lfsr;
    logic [WIDTH-1:0]   w_load_val;
    logic               w_shift;
    logic               w_load_seed;

    // Data is absorbed only in IDLE/SHIFT; the seed is restored while idle
    // and on the final OUT edge so each frame starts from SEED.
    assign w_shift     = ACTIVE && ((r_state == c_ST_IDLE) || (r_state == c_ST_SHIFT));
    assign w_load_seed = ((r_state == c_ST_IDLE) && !ACTIVE) ||
                         ((r_state == c_ST_OUT) && (r_cnt == c_CNT_LAST));

    crc_lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS[WIDTH-1:0]),
        .SEED  (SEED[WIDTH-1:0])
    ) u_lfsr (
        .clk         (CLK),
        .rst_n       (RST),
        .i_load_seed (w_load_seed),
        .i_shift     (w_shift),
        .i_data      (Data),
        .o_lfsr      (w_lfsr)
    );

`ifdef CRC_FINAL_XOR_EN
    localparam logic [WIDTH-1:0] c_XOR_OUT = XOR_OUT[WIDTH-1:0];
    assign w_load_val = w_lfsr ^ c_XOR_OUT;
`else
    assign w_load_val = w_lfsr;
`endif

    // The shifter holds the bits still to be sent: bit 0 goes straight to
    // CRC on the SHIFT->OUT edge, the rest are queued LSB-first.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            CRC     <= 1'b0;
            valid   <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ACTIVE) begin
                        r_state <= c_ST_SHIFT;
                        BUSY    <= 1'b1;
                    end
                end
                c_ST_SHIFT: begin
                    if (!ACTIVE) begin
                        r_state <= c_ST_OUT;
                        r_shreg <= w_load_val >> 1;
                        CRC     <= w_load_val[0];
                        valid   <= 1'b1;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                c_ST_OUT: begin
                    if (r_cnt != c_CNT_LAST) begin
                        CRC     <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                        CRC     <= 1'b0;
                        valid   <= 1'b0;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    CRC     <= 1'b0;
                    valid   <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_serial_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_serial_gen
// Description : Self-checking bench for crc_serial_gen. Two instances share
//               the stimulus: one with default parameters and one with
//               SEED=0. Expected outputs come from a per-frame CRC model and
//               a cycle timeline filled in when each frame is planned.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_serial_gen;

    localparam int          W      = 8;
    localparam int unsigned TAPS_A = 32'h44;
    localparam int unsigned SEED_A = 32'hD8;
    localparam int unsigned SEED_B = 32'h00;
    localparam int unsigned XOR_M  = 32'hFF;
    localparam int          NCYC   = 4096;
`ifdef CRC_FINAL_XOR_EN
    localparam int unsigned PIN_01    = 32'h54;
    localparam int unsigned PIN_ZEROS = 32'hFF;
`else
    localparam int unsigned PIN_01    = 32'hAB;
    localparam int unsigned PIN_ZEROS = 32'h00;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Data = 1'b0;
    logic ACTIVE = 1'b0;
    logic crc_a, valid_a, busy_a;
    logic crc_b, valid_b, busy_b;

    crc_serial_gen dut_a (
        .CLK(CLK), .RST(RST), .Data(Data), .ACTIVE(ACTIVE),
        .CRC(crc_a), .valid(valid_a), .BUSY(busy_a)
    );

    crc_serial_gen #(
        .WIDTH(8), .TAPS(32'h44), .SEED(32'h00), .XOR_OUT(32'hFF)
    ) dut_b (
        .CLK(CLK), .RST(RST), .Data(Data), .ACTIVE(ACTIVE),
        .CRC(crc_b), .valid(valid_b), .BUSY(busy_b)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    bit exp_busy  [NCYC];
    bit exp_valid [NCYC];
    bit exp_crc_a [NCYC];
    bit exp_crc_b [NCYC];

    int errors = 0;
    int checks = 0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Textbook Galois CRC over an LSB-first bit list.
    function automatic int unsigned model_crc(input int unsigned seed,
                                              input logic [63:0] bits, input int n);
        int unsigned r;
        int unsigned poly;
        bit          fb;
        r    = seed & 32'hFF;
        poly = (TAPS_A & 32'h7F) | 32'h80;
        for (int i = 0; i < n; i++) begin
            fb = bits[i] ^ r[0];
            r  = r >> 1;
            if (fb) r = r ^ poly;
        end
`ifdef CRC_FINAL_XOR_EN
        r = r ^ (XOR_M & 32'hFF);
`endif
        return r;
    endfunction

    // Frame whose first data edge is edge t: BUSY after edges t..t+n+W-1,
    // valid/CRC after edges t+n..t+n+W-1.
    task automatic plan(input int t, input int n, input int unsigned ca, input int unsigned cb);
        for (int k = 0; k < n + W; k++)
            if (t + k < NCYC) exp_busy[t + k] = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (t + n + k < NCYC) begin
                exp_valid[t + n + k] = 1'b1;
                exp_crc_a[t + n + k] = ca[k];
                exp_crc_b[t + n + k] = cb[k];
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last
    // OUT edge, so a following call starts on the first IDLE edge.
    task automatic send_frame(input logic [63:0] bits, input int n, input bit hold);
        plan(cyc + 1, n, model_crc(SEED_A, bits, n), model_crc(SEED_B, bits, n));
        for (int i = 0; i < n; i++) begin
            ACTIVE = 1'b1;
            Data   = bits[i];
            @(negedge CLK);
        end
        ACTIVE = 1'b0;
        Data   = 1'($urandom);
        @(negedge CLK);
        for (int k = 0; k < W; k++) begin
            ACTIVE = hold;
            Data   = 1'($urandom);
            @(negedge CLK);
        end
        ACTIVE = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            ACTIVE = 1'b0;
            Data   = 1'($urandom);
            @(negedge CLK);
        end
    endtask

    // Cycle-by-cycle comparison against the planned timeline.
    initial begin
        forever begin
            @(negedge CLK);
            if (cyc < NCYC) begin
                chk("busy_a",  busy_a,  exp_busy[cyc]);
                chk("valid_a", valid_a, exp_valid[cyc]);
                chk("crc_a",   crc_a,   exp_valid[cyc] ? exp_crc_a[cyc] : 1'b0);
                chk("busy_b",  busy_b,  exp_busy[cyc]);
                chk("valid_b", valid_b, exp_valid[cyc]);
                chk("crc_b",   crc_b,   exp_valid[cyc] ? exp_crc_b[cyc] : 1'b0);
                if (valid_a) cap_a = {crc_a, cap_a[W-1:1]};
                if (valid_b) cap_b = {crc_b, cap_b[W-1:1]};
            end
        end
    end

    initial begin
        logic [63:0] fr;
        int          n;

        // Model pins against hand-computed values.
        chk_val("model_pin_01",    model_crc(SEED_B, 64'h01, 8), PIN_01);
        chk_val("model_pin_zeros", model_crc(SEED_B, 64'h00, 16), PIN_ZEROS);

        repeat (3) @(negedge CLK);
        chk("rst_busy",  busy_a,  1'b0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_crc",   crc_a,   1'b0);
        RST = 1'b1;
        idle(2);

        // Frame 0x01 LSB-first.
        send_frame(64'h01, 8, 1'b0);
        chk_val("frame01_stream_b", 32'(cap_b), PIN_01);
        idle(2);

        // 16 zero bits.
        send_frame(64'h0, 16, 1'b0);
        chk_val("zeros_stream_b", 32'(cap_b), PIN_ZEROS);
        idle(1);

        // Minimum 1-bit frame.
        send_frame(64'h1, 1, 1'b0);
        idle(1);

        // ACTIVE kept high through OUT and straight into the next frame.
        fr = 64'($urandom);
        send_frame(fr, 8, 1'b1);
        fr = 64'($urandom);
        send_frame(fr, 8, 1'b1);
        chk_val("hold_stream_a", 32'(cap_a), model_crc(SEED_A, fr, 8));

        // Ten random 8-bit frames back-to-back.
        for (int f = 0; f < 10; f++) begin
            fr = 64'($urandom_range(0, 255));
            send_frame(fr, 8, 1'b0);
        end
        idle(2);

        // Random lengths.
        for (int f = 0; f < 4; f++) begin
            n  = $urandom_range(1, 40);
            fr = {$urandom, $urandom};
            send_frame(fr, n, 1'($urandom));
        end
        idle(2);

        // Abort with reset in the middle of OUT.
        fr = 64'($urandom);
        plan(cyc + 1, 8, model_crc(SEED_A, fr, 8), model_crc(SEED_B, fr, 8));
        for (int i = 0; i < 8; i++) begin
            ACTIVE = 1'b1;
            Data   = fr[i];
            @(negedge CLK);
        end
        ACTIVE = 1'b0;
        repeat (4) @(negedge CLK);
        #2;
        RST = 1'b0;
        for (int c = cyc + 1; c < NCYC; c++) begin
            exp_busy[c]  = 1'b0;
            exp_valid[c] = 1'b0;
        end
        #1;
        chk("abort_busy_a",  busy_a,  1'b0);
        chk("abort_valid_a", valid_a, 1'b0);
        chk("abort_crc_a",   crc_a,   1'b0);
        chk("abort_busy_b",  busy_b,  1'b0);
        chk("abort_valid_b", valid_b, 1'b0);
        chk("abort_crc_b",   crc_b,   1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(1);

        // Next frame must start from SEED.
        fr = 64'($urandom);
        send_frame(fr, 8, 1'b0);
        chk_val("post_abort_stream_a", 32'(cap_a), model_crc(SEED_A, fr, 8));
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
